// File: rtl/add8_err_monitor.sv
// add8_err_monitor
// Accuracy monitor for an approximate 8-bit adder. Each accepted triple
// (a, b, o_approx) is compared against the exact 9-bit sum. The block
// accumulates error statistics over a campaign: sample count, error count,
// sum of |error|, sum of error squared and worst-case error.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle pulse, clears statistics and opens a campaign
//   in_valid   : operand/result triple valid
//   in_ready   : block accepts a triple this cycle (registered, high only in RUN)
//   in_last    : marks the final triple of the campaign
//   a, b       : 8-bit adder operands
//   o_approx   : 9-bit approximate sum from the adder under test
//   n_samples  : accepted triples
//   n_err      : triples with nonzero error
//   sum_abs    : sum of |error|
//   sum_sq     : sum of error squared
//   wce        : worst-case |error|
//   ovf        : sample counter saturated
//   done       : campaign complete, statistics stable
module add8_err_monitor #(
  parameter int CNT_W = 17,
  parameter int PIPE  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  input  logic [8:0]          o_approx,
  output logic [CNT_W-1:0]    n_samples,
  output logic [CNT_W-1:0]    n_err,
  output logic [CNT_W+8:0]    sum_abs,
  output logic [CNT_W+17:0]   sum_sq,
  output logic [8:0]          wce,
  output logic                ovf,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_in_ready;

  // r_vld[0] is stage 1 occupancy, r_vld[PIPE-1] is the stage feeding the statistics.
  logic [PIPE-1:0]      r_vld;

  logic [8:0]           r_s1_sum;
  logic [8:0]           r_s1_approx;
  logic [8:0]           r_s1_abs;
  logic [8:0]           r_s2_abs;
  logic [17:0]          r_s2_sq;
  logic                 r_s2_nz;

  logic [CNT_W-1:0]     r_n_samples;
  logic [CNT_W-1:0]     r_n_err;
  logic [CNT_W+8:0]     r_sum_abs;
  logic [CNT_W+17:0]    r_sum_sq;
  logic [8:0]           r_wce;
  logic                 r_ovf;

  logic                 w_accept;
  logic [8:0]           w_sum;
  logic [8:0]           w_abs;
  logic                 w_update;

  assign w_accept = in_valid & r_in_ready;
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_abs    = (w_sum >= o_approx) ? (w_sum - o_approx) : (o_approx - w_sum);

  // Once the counter sits at its maximum every statistic freezes until start.
  assign w_update = r_vld[PIPE-1] & ~start & (r_n_samples != CNT_MAX);

  // State register. in_ready is registered from the next state so that it is
  // high exactly while the FSM sits in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == RUN);
    end
  end

  // Next-state logic. start wins from every state, including over a
  // simultaneous acceptance of a triple marked last.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = RUN;
    end else begin
      case (r_state)
        RUN:     if (w_accept && in_last) w_next_state = DRAIN;
        DRAIN:   if (r_vld == '0)         w_next_state = DONE;
        default: w_next_state = r_state;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    in_ready = r_in_ready;
    done     = (r_state == DONE);
  end

  // Two-stage datapath. start squashes anything entering or in flight, so a
  // restart never lets an old triple reach the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_s1_sum    <= '0;
      r_s1_approx <= '0;
      r_s1_abs    <= '0;
      r_s2_abs    <= '0;
      r_s2_sq     <= '0;
      r_s2_nz     <= 1'b0;
    end else begin
      r_vld       <= {r_vld[PIPE-2:0], w_accept} & {PIPE{~start}};
      r_s1_sum    <= w_sum;
      r_s1_approx <= o_approx;
      r_s1_abs    <= w_abs;
      r_s2_abs    <= r_s1_abs;
      r_s2_sq     <= {9'd0, r_s1_abs} * {9'd0, r_s1_abs};
      // Nonzero flag comes from the exact/approx comparison directly rather
      // than from the subtraction path.
      r_s2_nz     <= (r_s1_sum != r_s1_approx);
    end
  end

  // Statistics accumulators. ovf is raised by the update that brings the
  // sample counter to its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_samples <= '0;
      r_n_err     <= '0;
      r_sum_abs   <= '0;
      r_sum_sq    <= '0;
      r_wce       <= '0;
      r_ovf       <= 1'b0;
    end else if (start) begin
      r_n_samples <= '0;
      r_n_err     <= '0;
      r_sum_abs   <= '0;
      r_sum_sq    <= '0;
      r_wce       <= '0;
      r_ovf       <= 1'b0;
    end else if (w_update) begin
      r_n_samples <= r_n_samples + CNT_ONE;
      r_n_err     <= r_n_err + {{(CNT_W-1){1'b0}}, r_s2_nz};
      r_sum_abs   <= r_sum_abs + {{CNT_W{1'b0}}, r_s2_abs};
      r_sum_sq    <= r_sum_sq + {{CNT_W{1'b0}}, r_s2_sq};
      if (r_s2_abs > r_wce) begin
        r_wce <= r_s2_abs;
      end
      if (r_n_samples == (CNT_MAX - CNT_ONE)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign n_samples = r_n_samples;
  assign n_err     = r_n_err;
  assign sum_abs   = r_sum_abs;
  assign sum_sq    = r_sum_sq;
  assign wce       = r_wce;
  assign ovf       = r_ovf;

endmodule
